cci_mpf_prim_wr_rsp_sorter: RTL and testbench

Parametrised write-response reorder engine for the MPF shim stack. It sits between the AFU-side write request path and the host response channels. It allocates a ring slot per issued write and returns that slot index for substitution into the outgoing mdata. Responses arriving out of order on any of N_RSP_PORTS channels are collected, and the saved metadata is released in strict issue order through a single ready/valid output. This generalises the fixed two-channel scoreboard sorter with a configurable port count, downstream backpressure, occupancy reporting and protocol-error detection.

---
 rtl/cci_mpf_prim_wr_rsp_sorter.sv | 200 ++++++++++++++++++++
 tb/tb_cci_mpf_prim_wr_rsp_sorter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_prim_wr_rsp_sorter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cci_mpf_prim_wr_rsp_sorter
//
// Write-response reorder engine. Every issued write is given a ring slot. The
// slot index is returned to the requester so that it can travel in the
// outgoing mdata. Responses may come back in any order on any of N_RSP_PORTS
// channels. The saved metadata is released strictly in issue order through
// a single valid/ready output.
//
// Ports
//   clk_i            sole clock
//   reset_i          synchronous, active-high reset
//   alloc_en_i       a write is issued this cycle
//   alloc_meta_i     metadata (original mdata) saved for that write
//   alloc_idx_o      slot given to this cycle's allocation (current tail)
//   not_full_o       registered; more than MIN_FREE_SLOTS slots are free
//   rsp_valid_i      per-port response strobe
//   rsp_idx_i        per-port slot index, port p at [p*IDX_BITS +: IDX_BITS]
//   out_valid_o      oldest outstanding write has completed
//   out_meta_o       saved metadata of that write (0 when out_valid_o is low)
//   out_ready_i      downstream accepts out_meta_o this cycle
//   n_outstanding_o  allocated but not yet retired slots
//   empty_o          no outstanding slots (usable as a write fence)
//   err_o            sticky protocol-error flag, cleared only by reset
//
// Output handshake: a transfer happens on every cycle where out_valid_o and
// out_ready_i are both high. Once out_valid_o is raised it stays high, and
// out_meta_o stays unchanged, until that transfer happens. out_valid_o never
// depends combinationally on out_ready_i.
// ---------------------------------------------------------------------------
module cci_mpf_prim_wr_rsp_sorter #(
    parameter int N_ENTRIES      = 256,
    parameter int N_META_BITS    = 16,
    parameter int N_RSP_PORTS    = 2,
    parameter int MIN_FREE_SLOTS = 8,
    localparam int IDX_BITS      = $clog2(N_ENTRIES)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic                            alloc_en_i,
    input  logic [N_META_BITS-1:0]          alloc_meta_i,
    output logic [IDX_BITS-1:0]             alloc_idx_o,
    output logic                            not_full_o,

    input  logic [N_RSP_PORTS-1:0]          rsp_valid_i,
    input  logic [N_RSP_PORTS*IDX_BITS-1:0] rsp_idx_i,

    output logic                            out_valid_o,
    output logic [N_META_BITS-1:0]          out_meta_o,
    input  logic                            out_ready_i,

    output logic [IDX_BITS:0]               n_outstanding_o,
    output logic                            empty_o,
    output logic                            err_o
);

    localparam int CNT_W = IDX_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ENTRIES);
    localparam logic [CNT_W-1:0] MIN_FREE = CNT_W'(MIN_FREE_SLOTS);

    // Ring state
    logic [IDX_BITS-1:0]    head_q, head_d;
    logic [IDX_BITS-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [N_ENTRIES-1:0]   alloc_q, alloc_d;
    logic [N_ENTRIES-1:0]   done_q, done_d;
    logic [N_META_BITS-1:0] meta_q [N_ENTRIES];
    logic                   err_q, err_d;
    logic                   not_full_q, not_full_d;

    // Per-cycle decode
    logic [IDX_BITS-1:0]    rsp_idx [N_RSP_PORTS];
    logic [N_RSP_PORTS-1:0] port_dup;
    logic [N_ENTRIES-1:0]   done_set;
    logic                   rsp_err;
    logic                   full;
    logic                   retire;
    logic                   alloc_ok;
    logic [CNT_W-1:0]       free_d;

    for (genvar gp = 0; gp < N_RSP_PORTS; gp++) begin : g_rsp_idx
        assign rsp_idx[gp] = rsp_idx_i[gp*IDX_BITS +: IDX_BITS];
    end

    // ------------------------------------------------------------------
    // Output side: driven from registered state only.
    // ------------------------------------------------------------------
    assign out_valid_o     = alloc_q[head_q] & done_q[head_q];
    assign out_meta_o      = out_valid_o ? meta_q[head_q] : '0;
    assign alloc_idx_o     = tail_q;
    assign n_outstanding_o = count_q;
    assign empty_o         = (count_q == '0);
    assign err_o           = err_q;
    // Held low during reset; the register itself resets to the empty-ring
    // value so the flag is already high on the first cycle out of reset.
    assign not_full_o      = not_full_q & ~reset_i;

    assign full   = (count_q == FULL_CNT);
    assign retire = out_valid_o & out_ready_i;
    // A full ring still accepts a write when the head retires in the same
    // cycle: the slot being freed is exactly the tail, and the count is
    // unchanged. Only a write that has nowhere to go is dropped.
    assign alloc_ok = alloc_en_i & (~full | retire);

    // ------------------------------------------------------------------
    // Response decode. A port that repeats an index already named by a
    // lower-numbered port in the same cycle loses; the lower port's
    // response is still recorded.
    // ------------------------------------------------------------------
    always_comb begin
        port_dup = '0;
        for (int p = 0; p < N_RSP_PORTS; p++) begin
            for (int k = 0; k < p; k++) begin
                if (rsp_valid_i[p] && rsp_valid_i[k] && (rsp_idx[p] == rsp_idx[k])) begin
                    port_dup[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        done_set = '0;
        rsp_err  = 1'b0;
        for (int p = 0; p < N_RSP_PORTS; p++) begin
            if (rsp_valid_i[p]) begin
                // Slots allocated this very cycle are not yet marked, so a
                // same-cycle response to them lands here as an error too.
                if (port_dup[p] || !alloc_q[rsp_idx[p]] || done_q[rsp_idx[p]]) begin
                    rsp_err = 1'b1;
                end else begin
                    done_set[rsp_idx[p]] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        alloc_d = alloc_q;
        done_d  = done_q | done_set;

        // A response can never target a retiring head (it is already
        // done), so clearing after the merge is safe.
        if (retire) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + IDX_BITS'(1);
        end

        // Applied last so a full-ring allocate into the retiring slot wins.
        if (alloc_ok) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + IDX_BITS'(1);
        end

        count_d    = count_q + CNT_W'(alloc_ok) - CNT_W'(retire);
        free_d     = FULL_CNT - count_d;
        not_full_d = (free_d > MIN_FREE);
        err_d      = err_q | rsp_err | (alloc_en_i & ~alloc_ok);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            alloc_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            not_full_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            alloc_q    <= alloc_d;
            done_q     <= done_d;
            err_q      <= err_d;
            not_full_q <= not_full_d;
        end
    end

    // Metadata storage has no reset; a slot is only read once its alloc
    // bit has been set by a write to it.
    always_ff @(posedge clk_i) begin
        if (alloc_ok) begin
            meta_q[tail_q] <= alloc_meta_i;
        end
    end

endmodule

// File: tb/tb_cci_mpf_prim_wr_rsp_sorter.sv
`timescale 1ns/1ps
module tb_cci_mpf_prim_wr_rsp_sorter;

    localparam int N  = 16;
    localparam int MW = 16;
    localparam int NP = 2;
    localparam int MF = 2;
    localparam int IW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             alloc_en;
    logic [MW-1:0]    alloc_meta;
    logic [IW-1:0]    alloc_idx;
    logic             not_full;
    logic [NP-1:0]    rsp_valid;
    logic [NP*IW-1:0] rsp_idx;
    logic             out_valid;
    logic [MW-1:0]    out_meta;
    logic             out_ready;
    logic [IW:0]      n_out;
    logic             empty;
    logic             err;

    cci_mpf_prim_wr_rsp_sorter #(
        .N_ENTRIES      (N),
        .N_META_BITS    (MW),
        .N_RSP_PORTS    (NP),
        .MIN_FREE_SLOTS (MF)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .alloc_en_i      (alloc_en),
        .alloc_meta_i    (alloc_meta),
        .alloc_idx_o     (alloc_idx),
        .not_full_o      (not_full),
        .rsp_valid_i     (rsp_valid),
        .rsp_idx_i       (rsp_idx),
        .out_valid_o     (out_valid),
        .out_meta_o      (out_meta),
        .out_ready_i     (out_ready),
        .n_outstanding_o (n_out),
        .empty_o         (empty),
        .err_o           (err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errs   = 0;
    logic [MW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        alloc_en   = 1'b0;
        alloc_meta = '0;
        rsp_valid  = '0;
        rsp_idx    = '0;
    endtask

    task automatic alloc(input logic [MW-1:0] m);
        alloc_en   = 1'b1;
        alloc_meta = m;
        exp_q.push_back(m);
    endtask

    task automatic rsp(input int port, input logic [IW-1:0] idx);
        rsp_valid[port]          = 1'b1;
        rsp_idx[port*IW +: IW]   = idx;
    endtask

    // Called 1 time unit after a rising edge. Checks any retirement at the
    // falling edge, then advances to 1 unit after the next rising edge.
    task automatic tick();
        #4;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL sb_extra_retire: got meta 0x%0h, expected no retire", out_meta);
            end else begin
                chk("sb_order", 32'(out_meta), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        idle();
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          a_en;
        logic [MW-1:0] a_meta;
        logic [NP-1:0] rv;
        logic [IW-1:0] i0;
        logic [IW-1:0] i1;
        logic          rdy;
        logic          e_ov;
        logic [MW-1:0] e_om;
        logic [IW:0]   e_no;
        logic [IW-1:0] e_aidx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int a, input int m, input int rv, input int i0, input int i1,
                                input int rdy, input int ov, input int om, input int no, input int ai);
        vec_t v;
        v.a_en   = a[0];
        v.a_meta = m[MW-1:0];
        v.rv     = rv[NP-1:0];
        v.i0     = i0[IW-1:0];
        v.i1     = i1[IW-1:0];
        v.rdy    = rdy[0];
        v.e_ov   = ov[0];
        v.e_om   = om[MW-1:0];
        v.e_no   = no[IW:0];
        v.e_aidx = ai[IW-1:0];
        return v;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- test ----------------
    initial begin
        vec_t v;
        int allocd;
        int rspd;
        int cyc;

        // In order on port 0. Columns: alloc, meta, rsp_valid, idx0, idx1,
        // ready | expected out_valid, out_meta, n_outstanding, alloc_idx
        // (expected values are what is visible while the row is applied).
        tbl.push_back(mk(1, 'hA0, 0, 0, 0, 1,  0, 0,     0, 0));
        tbl.push_back(mk(1, 'hA1, 0, 0, 0, 1,  0, 0,     1, 1));
        tbl.push_back(mk(1, 'hA2, 0, 0, 0, 1,  0, 0,     2, 2));
        tbl.push_back(mk(1, 'hA3, 0, 0, 0, 1,  0, 0,     3, 3));
        tbl.push_back(mk(0, 0,    1, 0, 0, 1,  0, 0,     4, 4));
        tbl.push_back(mk(0, 0,    1, 1, 0, 1,  1, 'hA0,  4, 4));
        tbl.push_back(mk(0, 0,    1, 2, 0, 1,  1, 'hA1,  3, 4));
        tbl.push_back(mk(0, 0,    1, 3, 0, 1,  1, 'hA2,  2, 4));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  1, 'hA3,  1, 4));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0,     0, 4));
        // Reverse order across ports; idx 6/5 land together on two ports.
        tbl.push_back(mk(1, 'hB0, 0, 0, 0, 1,  0, 0,     0, 4));
        tbl.push_back(mk(1, 'hB1, 0, 0, 0, 1,  0, 0,     1, 5));
        tbl.push_back(mk(1, 'hB2, 0, 0, 0, 1,  0, 0,     2, 6));
        tbl.push_back(mk(1, 'hB3, 0, 0, 0, 1,  0, 0,     3, 7));
        tbl.push_back(mk(0, 0,    2, 0, 7, 1,  0, 0,     4, 8));
        tbl.push_back(mk(0, 0,    3, 5, 6, 1,  0, 0,     4, 8));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0,     4, 8));
        tbl.push_back(mk(0, 0,    1, 4, 0, 1,  0, 0,     4, 8));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  1, 'hB0,  4, 8));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  1, 'hB1,  3, 8));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  1, 'hB2,  2, 8));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  1, 'hB3,  1, 8));
        tbl.push_back(mk(0, 0,    0, 0, 0, 1,  0, 0,     0, 8));

        // ---- reset values ----
        reset     = 1'b1;
        idle();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_meta",  32'(out_meta),  0);
        chk("rst_n_out",     32'(n_out),     0);
        chk("rst_empty",     32'(empty),     1);
        chk("rst_err",       32'(err),       0);
        chk("rst_alloc_idx", 32'(alloc_idx), 0);
        chk("rst_not_full",  32'(not_full),  0);
        reset = 1'b0;
        #1;
        chk("post_rst_not_full", 32'(not_full), 1);
        @(posedge clk);
        #1;

        // ---- table ----
        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            idle();
            out_ready = v.rdy;
            if (v.a_en) alloc(v.a_meta);
            rsp_valid = v.rv;
            rsp_idx   = {v.i1, v.i0};
            chk($sformatf("row%0d_out_valid", r), 32'(out_valid), 32'(v.e_ov));
            chk($sformatf("row%0d_out_meta", r),  32'(out_meta),  32'(v.e_om));
            chk($sformatf("row%0d_n_out", r),     32'(n_out),     32'(v.e_no));
            chk($sformatf("row%0d_empty", r),     32'(empty),     32'(v.e_no == 0));
            chk($sformatf("row%0d_alloc_idx", r), 32'(alloc_idx), 32'(v.e_aidx));
            chk($sformatf("row%0d_err", r),       32'(err),       0);
            tick();
        end
        idle();

        // ---- full and wrap ----
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            idle();
            alloc(16'h1000 + i[15:0]);
            tick();
            if (i == 12) begin
                chk("full_n_out_13",    32'(n_out),    13);
                chk("full_not_full_13", 32'(not_full), 1);
            end
            if (i == 13) begin
                chk("full_not_full_14", 32'(not_full), 0);
            end
        end
        idle();
        chk("full_n_out_16",     32'(n_out),     16);
        chk("full_empty",        32'(empty),     0);
        chk("full_alloc_idx",    32'(alloc_idx), 0);
        chk("full_not_full_16",  32'(not_full),  0);
        allocd = 16;
        rspd   = 0;
        cyc    = 0;
        while ((allocd < 40 || exp_q.size() != 0) && cyc < 300) begin
            idle();
            if (rspd < allocd) begin
                rsp(rspd % 2, rspd[IW-1:0]);
                rspd++;
            end
            if (allocd < 40 && n_out < 14) begin
                alloc(16'h2000 + allocd[15:0]);
                allocd++;
            end
            tick();
            cyc++;
        end
        idle();
        chk("wrap_in_time",  32'(cyc < 300), 1);
        chk("wrap_err",      32'(err),       0);
        chk("wrap_empty",    32'(empty),     1);
        chk("wrap_tail",     32'(alloc_idx), 8);

        // ---- backpressure ----
        do_reset();
        alloc(16'hC000); tick(); idle();
        alloc(16'hC001); tick(); idle();
        alloc(16'hC002); tick(); idle();
        rsp(0, 0); rsp(1, 1); tick(); idle();
        rsp(0, 2); tick(); idle();
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_meta",  32'(out_meta),  32'h0000C000);
            chk("bp_n_out",     32'(n_out),     3);
            tick();
        end
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("bp_drained_n_out", 32'(n_out),     0);
        chk("bp_drained_valid", 32'(out_valid), 0);

        // ---- error: response to unallocated slot ----
        do_reset();
        alloc(16'hE000); tick(); idle();
        alloc(16'hE001); tick(); idle();
        chk("e1_err_before", 32'(err), 0);
        rsp(0, 7); tick(); idle();
        chk("e1_err",       32'(err),       1);
        chk("e1_n_out",     32'(n_out),     2);
        chk("e1_out_valid", 32'(out_valid), 0);
        tick();
        chk("e1_err_sticky", 32'(err), 1);
        rsp(0, 0); rsp(1, 1); tick(); idle();
        out_ready = 1'b1;
        tick(); tick();
        chk("e1_empty", 32'(empty), 1);

        // ---- error: duplicate response to the head ----
        do_reset();
        alloc(16'hF000); tick(); idle();
        alloc(16'hF001); tick(); idle();
        rsp(0, 0); tick(); idle();
        chk("e2_err_before", 32'(err),       0);
        chk("e2_valid",      32'(out_valid), 1);
        rsp(1, 0); tick(); idle();
        chk("e2_err",        32'(err),       1);
        chk("e2_out_meta",   32'(out_meta),  32'h0000F000);
        chk("e2_n_out",      32'(n_out),     2);
        rsp(0, 1);
        out_ready = 1'b1;
        tick(); idle();
        tick();
        chk("e2_empty", 32'(empty), 1);

        // ---- error: same index on both ports; port 0 still recorded ----
        do_reset();
        alloc(16'h6000); tick(); idle();
        alloc(16'h6001); tick(); idle();
        rsp(0, 1); rsp(1, 1); tick(); idle();
        chk("e3_err",       32'(err),       1);
        chk("e3_out_valid", 32'(out_valid), 0);
        rsp(0, 0); tick(); idle();
        chk("e3_head_meta", 32'(out_meta), 32'h00006000);
        out_ready = 1'b1;
        tick();
        chk("e3_second_valid", 32'(out_valid), 1);
        tick();
        chk("e3_empty", 32'(empty), 1);

        // ---- error: allocate into a full ring (dropped) ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle();
            alloc(16'h7000 + i[15:0]);
            tick();
        end
        idle();
        chk("e4_err_before", 32'(err),   0);
        chk("e4_n_out_16",   32'(n_out), 16);
        alloc_en   = 1'b1;
        alloc_meta = 16'hBAD0;
        tick(); idle();
        chk("e4_err",       32'(err),       1);
        chk("e4_n_out",     32'(n_out),     16);
        chk("e4_alloc_idx", 32'(alloc_idx), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle();
            rsp(0, 4'(2 * i));
            rsp(1, 4'(2 * i + 1));
            tick();
        end
        idle();
        repeat (10) tick();
        chk("e4_empty",    32'(empty),        1);
        chk("e4_sb_empty", 32'(exp_q.size()), 0);

        // ---- error: response in the allocating cycle ----
        do_reset();
        alloc(16'h8000); rsp(0, 0); tick(); idle();
        chk("e5_err",       32'(err),       1);
        chk("e5_out_valid", 32'(out_valid), 0);
        chk("e5_n_out",     32'(n_out),     1);
        rsp(0, 0); tick(); idle();
        out_ready = 1'b1;
        tick();
        chk("e5_empty", 32'(empty), 1);

        // ---- mid-operation reset ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            alloc(16'h9000 + i[15:0]);
            tick();
        end
        idle();
        rsp(0, 1); rsp(1, 3); tick(); idle();
        chk("mr_n_out_before", 32'(n_out), 5);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_n_out",     32'(n_out),     0);
        chk("mr_empty",     32'(empty),     1);
        chk("mr_err",       32'(err),       0);
        chk("mr_not_full",  32'(not_full),  0);
        reset = 1'b0;
        #1;
        chk("mr_not_full_after", 32'(not_full),  1);
        chk("mr_alloc_idx",      32'(alloc_idx), 0);
        @(posedge clk);
        #1;
        alloc(16'h9ABC); tick(); idle();
        rsp(0, 0); tick(); idle();
        out_ready = 1'b1;
        tick();
        chk("mr_final_empty", 32'(empty), 1);
        chk("mr_final_err",   32'(err),   0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
